sa_cache_controller: RTL



---
 rtl/sa_cache_controller.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sa_cache_controller.sv
// N-way set-associative, write-back, write-allocate cache controller.
// Flop-based tag/valid/dirty/data arrays with per-set round-robin replacement.
module sa_cache_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned SETS   = 64,
  parameter int unsigned WAYS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [LINE_W-1:0]   mem_req_wdata,
  input  logic                mem_resp_valid,
  input  logic [LINE_W-1:0]   mem_resp_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned WORDS  = LINE_W / DATA_W;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned BYTE_W = $clog2(DATA_W / 8);
  localparam int unsigned WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned IDX_W  = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, FILL_WAIT, RESP} state_t;

  state_t state;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [WAY_W-1:0]  vic_q;
  logic              vic_rr_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] word_sel;
  logic [ADDR_W-1:0] line_addr;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              victim_rr;
  logic [WAY_W-1:0]  rr_next;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] merged;
  logic [DATA_W-1:0] rd_word;

  // Address split, tag compare, victim choice and write merge for the latched request.
  always_comb begin
    idx       = IDX_W'(addr_q >> OFF_W);
    tag       = TAG_W'(addr_q >> (OFF_W + IDX_W));
    word_sel  = WSEL_W'(addr_q >> BYTE_W);
    line_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    hit       = 1'b0;
    hit_way   = '0;
    victim    = rr_q[idx];
    victim_rr = 1'b1;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        victim    = WAY_W'(w);
        victim_rr = 1'b0;
      end
    end
    rr_next  = (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + WAY_W'(1);
    hit_line = data_q[idx][hit_way];
    rd_word  = DATA_W'(hit_line >> (int'(word_sel) * int'(DATA_W)));
    merged   = hit_line;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (wstrb_q[b]) begin
        merged[int'(word_sel) * int'(DATA_W) + b * 8 +: 8] = wdata_q[b * 8 +: 8];
      end
    end
  end

  // Controller FSM with registered CPU and memory side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid <= 1'b1;
            if (we_q) begin
              data_q[idx][hit_way]  <= merged;
              dirty_q[idx][hit_way] <= 1'b1;
              resp_rdata            <= '0;
            end else begin
              resp_rdata <= rd_word;
            end
            state <= RESP;
          end else begin
            vic_q         <= victim;
            vic_rr_q      <= victim_rr;
            mem_req_valid <= 1'b1;
            if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
              mem_req_we    <= 1'b1;
              mem_req_addr  <= {tag_q[idx][victim], idx, {OFF_W{1'b0}}};
              mem_req_wdata <= data_q[idx][victim];
              state         <= WB;
            end else begin
              mem_req_we   <= 1'b0;
              mem_req_addr <= line_addr;
              state        <= REFILL;
            end
          end
        end
        WB: begin
          if (mem_req_ready) begin
            mem_req_we   <= 1'b0;
            mem_req_addr <= line_addr;
            state        <= REFILL;
          end
        end
        REFILL: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            data_q[idx][vic_q]  <= mem_resp_rdata;
            tag_q[idx][vic_q]   <= tag;
            valid_q[idx][vic_q] <= 1'b1;
            dirty_q[idx][vic_q] <= 1'b0;
            if (vic_rr_q) begin
              rr_q[idx] <= rr_next;
            end
            state <= LOOKUP;
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
